// File: rtl/time_code_rx.sv
// Pulse-width time-code receiver: synchronizes tc_in, classifies each high pulse
// into ZERO/ONE/MARK/BAD and assembles 32-bit MSB-first frames bounded by marks.
module time_code_rx #(
   parameter int unsigned CELL = 5000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tc_in,
   output logic [31:0] time_word,
   output logic        time_valid,
   output logic        locked,
   output logic        err,
   output logic [7:0]  err_cnt
);

   localparam int unsigned CW = $clog2(2 * CELL + 1);

   localparam logic [CW-1:0] W_MAX   = CW'(2 * CELL);
   localparam logic [CW-1:0] T_ZERO  = CW'(CELL / 10);
   localparam logic [CW-1:0] T_ONE   = CW'((7 * CELL) / 20);
   localparam logic [CW-1:0] T_MARK  = CW'((13 * CELL) / 20);
   localparam logic [CW-1:0] T_BAD   = CW'((19 * CELL) / 20);
   localparam logic [CW-1:0] TO_LAST = CW'(2 * CELL - 1);

   typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_END} state_t;
   typedef enum logic [2:0] {SYM_NONE, SYM_ZERO, SYM_ONE, SYM_MARK, SYM_BAD} sym_t;

   state_t        state_q, state_d;
   sym_t          sym;
   logic          tc_s1, tc_s2, tc_s3;
   logic          rise, fall, timeout;
   logic [CW-1:0] w_q, to_q;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   shift_q, shift_d, word_d;
   logic          valid_d, err_d, locked_d;

   // NOTE: every clocked process uses non-blocking assignments so all registers
   // update together on the edge regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tc_s1 <= 1'b0;
         tc_s2 <= 1'b0;
         tc_s3 <= 1'b0;
      end else begin
         tc_s1 <= tc_in;
         tc_s2 <= tc_s1;
         tc_s3 <= tc_s2;
      end
   end

   assign rise = tc_s2 & ~tc_s3;
   assign fall = ~tc_s2 & tc_s3;

   // Width counts synchronized high cycles; timeout counts low cycles since the fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_q  <= '0;
         to_q <= '0;
      end else begin
         if (!tc_s2)
            w_q <= '0;
         else if (rise)
            w_q <= CW'(1);
         else if (w_q != W_MAX)
            w_q <= w_q + CW'(1);

         if (tc_s2)
            to_q <= '0;
         else if (to_q != W_MAX)
            to_q <= to_q + CW'(1);
      end
   end

   assign timeout = ~tc_s2 && (to_q == TO_LAST);

   always_comb begin
      sym = SYM_NONE;
      if (fall) begin
         if (w_q < T_ZERO)
            sym = SYM_NONE;
         else if (w_q < T_ONE)
            sym = SYM_ZERO;
         else if (w_q < T_MARK)
            sym = SYM_ONE;
         else if (w_q < T_BAD)
            sym = SYM_MARK;
         else
            sym = SYM_BAD;
      end
   end

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      word_d    = time_word;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      locked_d  = locked;

      case (state_q)
         ST_HUNT: begin
            if (sym == SYM_MARK) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            case (sym)
               SYM_ZERO, SYM_ONE: begin
                  shift_d   = {shift_q[30:0], sym == SYM_ONE};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd31)
                     state_d = ST_END;
               end
               SYM_MARK: begin
                  err_d     = 1'b1;
                  bit_cnt_d = '0;
               end
               SYM_BAD: begin
                  err_d   = 1'b1;
                  state_d = ST_HUNT;
               end
               default: begin
                  if (timeout) begin
                     err_d   = 1'b1;
                     state_d = ST_HUNT;
                  end
               end
            endcase
         end
         ST_END: begin
            if (sym == SYM_MARK) begin
               word_d    = shift_q;
               valid_d   = 1'b1;
               locked_d  = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end else if (sym != SYM_NONE || timeout) begin
               err_d   = 1'b1;
               state_d = ST_HUNT;
            end
         end
         default: state_d = ST_HUNT;
      endcase

      if (err_d)
         locked_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_HUNT;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         time_word  <= '0;
         time_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         time_word  <= word_d;
         time_valid <= valid_d;
         locked     <= locked_d;
         err        <= err_d;
         if (err_d && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_time_code_rx.sv
// Self-checking bench for time_code_rx with CELL=100: classification table,
// directed frame/error sequences and a randomized run against a symbol-level model.
module tb_time_code_rx;

   localparam int CELL = 100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tc_in = 1'b0;
   logic [31:0] time_word;
   logic        time_valid;
   logic        locked;
   logic        err;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   time_code_rx #(.CELL(CELL)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tc_in      (tc_in),
      .time_word  (time_word),
      .time_valid (time_valid),
      .locked     (locked),
      .err        (err),
      .err_cnt    (err_cnt)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Output monitor: counts pulses and records every delivered word.
   int          n_valid = 0;
   int          n_err   = 0;
   logic [31:0] words_q[$];

   always @(negedge clk) begin
      if (time_valid) begin
         n_valid++;
         words_q.push_back(time_word);
      end
      if (err)
         n_err++;
   end

   int v0, e0, w0;

   // Reference model: a frame is 32 data symbols between two marks; anything
   // else after an opening mark is an error.
   bit          m_open;
   bit          m_bits[$];
   int          m_errs, m_valids, m_low;
   logic [31:0] m_word;
   bit          m_locked;

   function automatic int sym_of(input int w);
      if (w < CELL / 10)             return 0;
      else if (w < 7 * CELL / 20)    return 1;
      else if (w < 13 * CELL / 20)   return 2;
      else if (w < 19 * CELL / 20)   return 3;
      else                           return 4;
   endfunction

   task automatic model_error();
      m_errs++;
      m_locked = 1'b0;
   endtask

   task automatic model_pulse(input int w);
      int s;
      logic [31:0] v;
      s = sym_of(w);
      m_low = 0;
      case (s)
         1, 2: if (m_open) begin
            if (m_bits.size() == 32) begin
               model_error();
               m_open = 1'b0;
            end else
               m_bits.push_back(s == 2);
         end
         3: begin
            if (m_open) begin
               if (m_bits.size() == 32) begin
                  v = '0;
                  foreach (m_bits[i]) v = {v[30:0], m_bits[i]};
                  m_word = v;
                  m_valids++;
                  m_locked = 1'b1;
               end else
                  model_error();
            end
            m_open = 1'b1;
            m_bits.delete();
         end
         4: if (m_open) begin
            model_error();
            m_open = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic model_low(input int n);
      m_low += n;
      if (m_open && m_low >= 2 * CELL) begin
         model_error();
         m_open = 1'b0;
      end
   endtask

   // Stimulus: all drives happen on the falling clock edge.
   task automatic high(input int w);
      tc_in = 1'b1;
      repeat (w) @(negedge clk);
      tc_in = 1'b0;
      model_pulse(w);
   endtask

   task automatic low(input int n);
      tc_in = 1'b0;
      repeat (n) @(negedge clk);
      model_low(n);
   endtask

   task automatic pulse(input int w, input int gap);
      high(w);
      low(gap);
   endtask

   task automatic mark(input bit full);
      pulse(80, full ? 20 : 5);
   endtask

   task automatic send_range(input logic [31:0] v, input int hi, input int lo, input bit full);
      for (int i = hi; i >= lo; i--) begin
         if (full)
            pulse(v[i] ? 50 : 20, v[i] ? 50 : 80);
         else
            pulse(v[i] ? 45 : 20, 5);
      end
   endtask

   task automatic do_reset();
      tc_in   = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      m_open = 1'b0; m_bits.delete(); m_errs = 0; m_valids = 0;
      m_word = '0; m_locked = 1'b0; m_low = 0;
      v0 = n_valid; e0 = n_err; w0 = words_q.size();
   endtask

   typedef struct {
      int          w;
      int          exp_valids;
      logic [31:0] exp_word;
      int          exp_errs;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{9,   0, 32'h0,        1};  // glitch: 31 bits then mark is short
      vecs[1] = '{10,  1, 32'h0,        0};
      vecs[2] = '{34,  1, 32'h0,        0};
      vecs[3] = '{35,  1, 32'h80000000, 0};
      vecs[4] = '{64,  1, 32'h80000000, 0};
      vecs[5] = '{65,  0, 32'h0,        2};  // mark in data, then short frame
      vecs[6] = '{94,  0, 32'h0,        2};
      vecs[7] = '{95,  0, 32'h0,        1};  // bad width drops to hunt
      vecs[8] = '{150, 0, 32'h0,        1};

      do_reset();
      check("rst_word",   time_word, 32'h0);
      check("rst_valid",  time_valid, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_err",    err, 1'b0);
      check("rst_errcnt", err_cnt, 8'h0);

      // Width classification boundaries: one test pulse after a mark, then 31 zeros and a mark.
      foreach (vecs[i]) begin
         do_reset();
         mark(0);
         pulse(vecs[i].w, 5);
         send_range(32'h0, 30, 0, 0);
         mark(0);
         check($sformatf("tbl_w%0d_valids", vecs[i].w), n_valid - v0, vecs[i].exp_valids);
         check($sformatf("tbl_w%0d_word",   vecs[i].w), time_word, vecs[i].exp_word);
         check($sformatf("tbl_w%0d_errs",   vecs[i].w), n_err - e0, vecs[i].exp_errs);
      end

      // Clean full-cell frame with closing-mark latency.
      do_reset();
      mark(1);
      send_range(32'hDEADBEEF, 31, 0, 1);
      high(80);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("lat_edge%0d", k), time_valid, k == 3);
      end
      low(20);
      check("clean_word",   time_word, 32'hDEADBEEF);
      check("clean_valids", n_valid - v0, 1);
      check("clean_locked", locked, 1'b1);
      check("clean_errcnt", err_cnt, 8'h0);

      // Back-to-back frames sharing the middle mark.
      do_reset();
      mark(0);
      send_range(32'h00000001, 31, 0, 0);
      mark(0);
      send_range(32'h80000000, 31, 0, 0);
      mark(0);
      check("b2b_valids", n_valid - v0, 2);
      check("b2b_errcnt", err_cnt, 8'h0);
      if (words_q.size() >= w0 + 2) begin
         check("b2b_word0", words_q[w0],     32'h00000001);
         check("b2b_word1", words_q[w0 + 1], 32'h80000000);
      end else
         check("b2b_words_present", words_q.size() - w0, 2);

      // Glitch mid-frame, then a bad width while locked.
      do_reset();
      mark(0);
      send_range(32'hA5A5C3C3, 31, 16, 0);
      pulse(5, 5);
      send_range(32'hA5A5C3C3, 15, 0, 0);
      mark(0);
      check("glitch_word",   time_word, 32'hA5A5C3C3);
      check("glitch_errcnt", err_cnt, 8'h0);
      check("glitch_locked", locked, 1'b1);
      pulse(97, 5);
      check("bad_errs",    n_err - e0, 1);
      check("bad_locked",  locked, 1'b0);
      check("bad_errcnt",  err_cnt, 8'h1);
      mark(0);
      send_range(32'h0F0F1234, 31, 0, 0);
      mark(0);
      check("bad_recover_word",   time_word, 32'h0F0F1234);
      check("bad_recover_valids", n_valid - v0, 2);
      check("bad_recover_locked", locked, 1'b1);

      // Mark inside data restarts the frame.
      do_reset();
      mark(0);
      send_range(32'hFFFFFFFF, 9, 0, 0);
      mark(0);
      send_range(32'h12345678, 31, 0, 0);
      mark(0);
      check("mid_mark_errcnt", err_cnt, 8'h1);
      check("mid_mark_word",   time_word, 32'h12345678);
      check("mid_mark_valids", n_valid - v0, 1);

      // Timeout returns to hunt: following bits are ignored until a mark.
      do_reset();
      mark(0);
      send_range(32'h0000001F, 4, 0, 0);
      low(250);
      check("to_errs",   n_err - e0, 1);
      check("to_errcnt", err_cnt, 8'h1);
      send_range(32'hFFFFFFFF, 31, 0, 0);
      mark(0);
      check("to_hunt_valids", n_valid - v0, 0);
      check("to_hunt_errcnt", err_cnt, 8'h1);

      // Reset mid-frame abandons the frame.
      do_reset();
      mark(0);
      send_range(32'hCAFEF00D, 31, 0, 0);
      mark(0);
      send_range(32'h3C3C3C3C, 31, 22, 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_word",   time_word, 32'h0);
      check("mid_rst_locked", locked, 1'b0);
      check("mid_rst_valid",  time_valid, 1'b0);
      check("mid_rst_err",    err, 1'b0);
      do_reset();
      send_range(32'h3C3C3C3C, 21, 0, 0);
      mark(0);
      check("post_rst_valids", n_valid - v0, 0);
      send_range(32'h3C3C3C3C, 31, 0, 0);
      mark(0);
      check("post_rst_word",   time_word, 32'h3C3C3C3C);
      check("post_rst_valids2", n_valid - v0, 1);

      // Randomized mix against the model.
      do_reset();
      mark(0);
      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 3))
            0: send_range($urandom, 31, 0, 0);
            1: mark(0);
            2: pulse($urandom_range(1, 110), 5);
            default: low(260);
         endcase
         check($sformatf("rnd%0d_errs",   n), n_err - e0, m_errs);
         check($sformatf("rnd%0d_valids", n), n_valid - v0, m_valids);
         check($sformatf("rnd%0d_locked", n), locked, m_locked);
         check($sformatf("rnd%0d_errcnt", n), err_cnt, (m_errs > 255) ? 255 : m_errs);
         if (m_valids > 0)
            check($sformatf("rnd%0d_word", n), time_word, m_word);
      end
      mark(0);
      send_range(32'h5EED5EED, 31, 0, 0);
      mark(0);
      check("rnd_final_word",   time_word, m_word);
      check("rnd_final_valids", n_valid - v0, m_valids);

      // Error counter saturation.
      do_reset();
      repeat (300) begin
         pulse(70, 4);
         pulse(96, 4);
      end
      check("sat_errs",   n_err - e0, 300);
      check("sat_errcnt", err_cnt, 8'hFF);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
